// File: rtl/ex_mdu_seq.sv
`timescale 1ns/1ps
// ex_mdu_seq: iterative unsigned multiply/divide unit.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// WIDTH steps per operation. The hi/lo register pair serves both operations:
//   multiply: {hi,lo} starts as {0, multiplier} and ends as the 2*WIDTH product
//   divide:   {hi,lo} starts as {0, dividend}   and ends as {remainder, quotient}
// A zero divisor therefore naturally yields quotient all-ones and remainder rs1.
module ex_mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic [4:0]       rd_in,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       rd_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [4:0]       rd_r;

   logic             accept_s;
   logic             step_s;
   logic             finish_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_shift_s;
   logic [WIDTH-1:0] div_diff_s;
   logic             div_ge_s;
   logic [WIDTH-1:0] hi_nxt_s;
   logic [WIDTH-1:0] lo_nxt_s;
   logic [WIDTH-1:0] res_nxt_s;

   // State register; reset drops straight back to IDLE, abandoning any operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode plus the handshake outputs derived from the current state.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      step_s      = 1'b0;
      finish_s    = 1'b0;
      stall       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_r)
         IDLE: begin
            // Stall is gated by reset so it reads 0 while reset is held.
            stall = start & ~flush & reset_n;
            if (start && !flush) begin
               accept_s    = 1'b1;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            stall = 1'b1;
            busy  = 1'b1;
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == CNT_LAST) begin
               step_s      = 1'b1;
               finish_s    = 1'b1;
               state_nxt_s = DONE;
            end else begin
               step_s      = 1'b1;
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            // A flush here cannot cancel the pulse already being presented.
            done        = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // One iteration of shift-add multiply or restoring divide on the hi/lo pair.
   always_comb begin
      mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
      div_shift_s = {hi_r, lo_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, b_r});
      div_diff_s  = div_shift_s[WIDTH-1:0] - b_r;
      hi_nxt_s    = hi_r;
      lo_nxt_s    = lo_r;
      if (!op_r[1]) begin
         hi_nxt_s = mul_sum_s[WIDTH:1];
         lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      end else if (div_ge_s) begin
         hi_nxt_s = div_diff_s;
         lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
         hi_nxt_s = div_shift_s[WIDTH-1:0];
         lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
      end
      // op[0] selects the upper half: MULHU high product, REMU remainder.
      res_nxt_s = op_r[0] ? hi_nxt_s : lo_nxt_s;
   end

   // Operand latch, iteration state and the result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r  <= {CW{1'b0}};
         op_r   <= 2'b00;
         a_r    <= {WIDTH{1'b0}};
         b_r    <= {WIDTH{1'b0}};
         hi_r   <= {WIDTH{1'b0}};
         lo_r   <= {WIDTH{1'b0}};
         rd_r   <= 5'd0;
         result <= {WIDTH{1'b0}};
         rd_out <= 5'd0;
      end else if (accept_s) begin
         cnt_r <= {CW{1'b0}};
         op_r  <= op;
         a_r   <= rs1;
         b_r   <= rs2;
         hi_r  <= {WIDTH{1'b0}};
         lo_r  <= op[1] ? rs1 : rs2;
         rd_r  <= rd_in;
      end else if (step_s) begin
         cnt_r <= cnt_r + CW'(1);
         hi_r  <= hi_nxt_s;
         lo_r  <= lo_nxt_s;
         if (finish_s) begin
            result <= res_nxt_s;
            rd_out <= rd_r;
         end else begin
            result <= result;
            rd_out <= rd_out;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule
